// File: rtl/m_shared_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : m_shared_bus_sequencer
//  Purpose  : Lets the J1A CPU and a video fetch requester share one
//             single-ported Wishbone memory. The J1A's lock-stepped
//             instruction/data buses (one shared STB/ACK) are split into a
//             sequential INS phase and an optional DAT phase; the CPU sees a
//             single ACK pulse once all required phases are done. Video
//             reads are interleaved round-robin between CPU transactions.
//  Ports    : sys_clk_i/sys_res_i     clock, synchronous active-high reset
//             cpu_*                   J1A shared-strobe bus (ins + dat)
//             vid_*                   video read requester
//             mem_*                   single Wishbone master port to memory
//  Revision : 1.0  initial release
// ============================================================================
module m_shared_bus_sequencer #(
    parameter logic [1:0] INS_BASE = 2'b00
) (
    input  logic        sys_clk_i,
    input  logic        sys_res_i,
    // J1A CPU
    input  logic        cpu_stb_i,
    input  logic [12:0] cpu_ins_adr_i,
    output logic [15:0] cpu_ins_dat_o,
    input  logic [14:0] cpu_dat_adr_i,
    input  logic [15:0] cpu_dat_dat_i,
    output logic [15:0] cpu_dat_dat_o,
    output logic        cpu_ack_o,
    // video fetch
    input  logic        vid_cyc_i,
    input  logic [14:0] vid_adr_i,
    output logic [15:0] vid_dat_o,
    output logic        vid_ack_o,
    // memory
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [14:0] mem_adr_o,
    output logic [15:0] mem_dat_o,
    input  logic [15:0] mem_dat_i,
    input  logic        mem_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INS  = 3'd1,
        S_DEC  = 3'd2,
        S_DAT  = 3'd3,
        S_CACK = 3'd4,
        S_VID  = 3'd5,
        S_VACK = 3'd6
    } state_t;

    state_t      r_state;
    logic        r_stb;
    logic        r_we;
    logic [14:0] r_adr;
    logic [15:0] r_ins_dat;
    logic [15:0] r_dat_dat;
    logic [15:0] r_vid_dat;
    logic        r_cpu_ack;
    logic        r_vid_ack;
    logic        r_last_vid;   // 1: video was granted last, so CPU wins a tie

    logic        w_grant_cpu;
    logic        w_is_mem_op;
    logic        w_need_dat;
    logic        w_is_wr;

    // Round-robin: CPU wins unless video also asks and the CPU went last.
    assign w_grant_cpu = cpu_stb_i && (!vid_cyc_i || r_last_vid);

    // J1A ALU-class instructions (011) carry the memory-read (T field 4'hC)
    // and N->[T] store (bit 5) side effects that need a data phase.
    assign w_is_mem_op = (r_ins_dat[15:13] == 3'b011);
    assign w_need_dat  = w_is_mem_op && ((r_ins_dat[11:8] == 4'hC) || r_ins_dat[5]);
    assign w_is_wr     = w_is_mem_op && r_ins_dat[5];

    always_ff @(posedge sys_clk_i) begin
        if (sys_res_i) begin
            r_state    <= S_IDLE;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= 15'd0;
            r_ins_dat  <= 16'h0000;
            r_dat_dat  <= 16'h0000;
            r_vid_dat  <= 16'h0000;
            r_cpu_ack  <= 1'b0;
            r_vid_ack  <= 1'b0;
            r_last_vid <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_cpu) begin
                        r_state <= S_INS;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b0;
                        r_adr   <= {INS_BASE, cpu_ins_adr_i};
                    end else if (vid_cyc_i) begin
                        r_state <= S_VID;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b0;
                        r_adr   <= vid_adr_i;
                    end
                end
                S_INS: begin
                    if (mem_ack_i) begin
                        r_ins_dat <= mem_dat_i;
                        r_stb     <= 1'b0;
                        r_state   <= S_DEC;
                    end
                end
                S_DEC: begin
                    if (w_need_dat) begin
                        r_state <= S_DAT;
                        r_stb   <= 1'b1;
                        r_we    <= w_is_wr;
                        r_adr   <= cpu_dat_adr_i;
                    end else begin
                        r_state   <= S_CACK;
                        r_cpu_ack <= 1'b1;
                    end
                end
                S_DAT: begin
                    if (mem_ack_i) begin
                        if (!r_we) begin
                            r_dat_dat <= mem_dat_i;
                        end
                        r_stb     <= 1'b0;
                        r_we      <= 1'b0;
                        r_cpu_ack <= 1'b1;
                        r_state   <= S_CACK;
                    end
                end
                S_CACK: begin
                    r_cpu_ack  <= 1'b0;
                    r_last_vid <= 1'b0;
                    r_state    <= S_IDLE;
                end
                S_VID: begin
                    if (mem_ack_i) begin
                        r_vid_dat <= mem_dat_i;
                        r_stb     <= 1'b0;
                        r_vid_ack <= 1'b1;
                        r_state   <= S_VACK;
                    end
                end
                S_VACK: begin
                    r_vid_ack  <= 1'b0;
                    r_last_vid <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ins_dat_o = r_ins_dat;
    assign cpu_dat_dat_o = r_dat_dat;
    assign cpu_ack_o     = r_cpu_ack;
    assign vid_dat_o     = r_vid_dat;
    assign vid_ack_o     = r_vid_ack;
    assign mem_cyc_o     = r_stb;
    assign mem_stb_o     = r_stb;
    assign mem_we_o      = r_we;
    assign mem_adr_o     = r_adr;
    assign mem_dat_o     = cpu_dat_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_m_shared_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_shared_bus_sequencer
//  Purpose  : Self-checking bench for m_shared_bus_sequencer. A wait-state
//             programmable memory drives the bus; a shadow memory plus
//             per-transaction rules give the expected phases, latencies and
//             captured data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_shared_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_stb;
    logic [12:0] ins_adr;
    logic [15:0] ins_dat;
    logic [14:0] dat_adr;
    logic [15:0] dat_wd;
    logic [15:0] dat_rd;
    logic        cpu_ack;
    logic        vid_cyc;
    logic [14:0] vid_adr;
    logic [15:0] vid_dat;
    logic        vid_ack;
    logic        mem_cyc;
    logic        mem_stb;
    logic        mem_we;
    logic [14:0] mem_adr;
    logic [15:0] mem_wd;
    logic [15:0] mem_rd;
    logic        mem_ack;

    always #5 clk = ~clk;

    m_shared_bus_sequencer #(.INS_BASE(2'b00)) u_dut (
        .sys_clk_i     (clk),
        .sys_res_i     (rst),
        .cpu_stb_i     (cpu_stb),
        .cpu_ins_adr_i (ins_adr),
        .cpu_ins_dat_o (ins_dat),
        .cpu_dat_adr_i (dat_adr),
        .cpu_dat_dat_i (dat_wd),
        .cpu_dat_dat_o (dat_rd),
        .cpu_ack_o     (cpu_ack),
        .vid_cyc_i     (vid_cyc),
        .vid_adr_i     (vid_adr),
        .vid_dat_o     (vid_dat),
        .vid_ack_o     (vid_ack),
        .mem_cyc_o     (mem_cyc),
        .mem_stb_o     (mem_stb),
        .mem_we_o      (mem_we),
        .mem_adr_o     (mem_adr),
        .mem_dat_o     (mem_wd),
        .mem_dat_i     (mem_rd),
        .mem_ack_i     (mem_ack)
    );

    // ---------------- memory environment and shadow model ----------------
    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    int          wait_n;
    bit          block_ack;
    bit          force_ack;
    int          wcnt;

    assign mem_ack = force_ack || (mem_stb && !block_ack && (wcnt >= wait_n));
    assign mem_rd  = mem[mem_adr];

    always @(posedge clk) begin
        if (mem_stb && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    int total = 0;
    int bad   = 0;

    // observation record of one transaction
    logic [14:0] obs_adr [4];
    logic        obs_we  [4];
    logic [15:0] obs_wd  [4];
    int          obs_len [4];
    int          obs_n, obs_lat, obs_wrong, obs_cycbad;
    logic [15:0] obs_idat, obs_cdat, obs_vdat;

    task automatic put(input logic [14:0] a, input logic [15:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cpu_stb = 1'b0; vid_cyc = 1'b0;
        block_ack = 1'b0; force_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Collect phases and the ack cycle of one transaction (no judging here).
    task automatic watch(input bit want_vid, input int limit);
        bit prev;
        prev = 1'b0; obs_n = 0; obs_lat = -1; obs_wrong = 0; obs_cycbad = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (mem_cyc !== mem_stb) obs_cycbad++;
            if (mem_stb) begin
                if (!prev) begin
                    if (obs_n < 4) begin
                        obs_adr[obs_n] = mem_adr; obs_we[obs_n] = mem_we;
                        obs_wd[obs_n] = mem_wd;   obs_len[obs_n] = 0;
                    end
                    obs_n++;
                end
                if (obs_n <= 4) obs_len[obs_n-1]++;
                if (mem_ack && mem_we) mem[mem_adr] = mem_wd;
            end
            prev = mem_stb;
            if (want_vid ? cpu_ack : vid_ack) obs_wrong++;
            if (want_vid ? vid_ack : cpu_ack) begin
                obs_lat = c; obs_idat = ins_dat; obs_cdat = dat_rd; obs_vdat = vid_dat;
                break;
            end
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        total++; if ({mem_stb, mem_cyc, mem_we, cpu_ack, vid_ack} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 00000", {mem_stb, mem_cyc, mem_we, cpu_ack, vid_ack}); end
        total++; if ({ins_dat, dat_rd, vid_dat} !== 48'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {ins_dat, dat_rd, vid_dat}); end
        total++; if (mem_adr !== 15'd0) begin
            bad++; $display("FAIL reset_adr: got %h want 0", mem_adr); end
    endtask

    task automatic test_fetch();
        do_reset();
        wait_n = 0; put(15'h0000, 16'h8005); ins_adr = 13'h0000;
        cpu_stb = 1'b1; watch(0, 50); cpu_stb = 1'b0;
        total++; if (obs_lat !== 3) begin bad++; $display("FAIL fetch_lat: got %0d want 3", obs_lat); end
        total++; if (obs_n !== 1) begin bad++; $display("FAIL fetch_phases: got %0d want 1", obs_n); end
        total++; if (obs_adr[0] !== 15'h0000 || obs_we[0] !== 1'b0) begin
            bad++; $display("FAIL fetch_ins: got adr %h we %b want 0000 0", obs_adr[0], obs_we[0]); end
        total++; if (obs_idat !== 16'h8005) begin bad++; $display("FAIL fetch_word: got %h want 8005", obs_idat); end
        @(negedge clk);
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL fetch_pulse: got %b want 0", cpu_ack); end
    endtask

    task automatic test_load_store();
        // load
        put(15'h0001, 16'h6C00); put(15'h0100, 16'hBEEF);
        ins_adr = 13'h0001; dat_adr = 15'h0100; dat_wd = 16'h5555;
        cpu_stb = 1'b1; watch(0, 50); cpu_stb = 1'b0;
        total++; if (obs_lat !== 4) begin bad++; $display("FAIL load_lat: got %0d want 4", obs_lat); end
        total++; if (obs_n !== 2 || obs_adr[1] !== 15'h0100 || obs_we[1] !== 1'b0) begin
            bad++; $display("FAIL load_dat: got n %0d adr %h we %b want 2 0100 0", obs_n, obs_adr[1], obs_we[1]); end
        total++; if (obs_cdat !== 16'hBEEF) begin bad++; $display("FAIL load_data: got %h want beef", obs_cdat); end
        @(negedge clk);
        // store
        put(15'h0002, 16'h6020);
        ins_adr = 13'h0002; dat_adr = 15'h0200; dat_wd = 16'h1234;
        cpu_stb = 1'b1; watch(0, 50); cpu_stb = 1'b0;
        total++; if (obs_n !== 2 || obs_we[1] !== 1'b1 || obs_wd[1] !== 16'h1234 || obs_adr[1] !== 15'h0200) begin
            bad++; $display("FAIL store_dat: got n %0d we %b wd %h adr %h want 2 1 1234 0200",
                            obs_n, obs_we[1], obs_wd[1], obs_adr[1]); end
        total++; if (obs_cdat !== 16'hBEEF) begin bad++; $display("FAIL store_keep: got %h want beef", obs_cdat); end
        total++; if (obs_lat !== 4) begin bad++; $display("FAIL store_lat: got %0d want 4", obs_lat); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int grants, run;
        logic [14:0] va;
        logic [15:0] exp_v;
        do_reset();
        wait_n = 2; put(15'h0010, 16'h8005); ins_adr = 13'h0010;
        va = 15'($urandom); vid_adr = va; exp_v = ref_mem[va];
        cpu_stb = 1'b1; vid_cyc = 1'b1;
        grants = 0; run = 0;
        for (int c = 0; c < 200 && grants < 4; c++) begin
            @(negedge clk);
            if (mem_stb) begin
                run++;
                if (mem_ack) begin
                    total++; if (run !== 3) begin bad++; $display("FAIL cont_phase_len: got %0d want 3", run); end
                    run = 0;
                end
            end
            if (cpu_ack) begin
                total++; if (grants % 2 != 0) begin bad++; $display("FAIL cont_order: got CPU at grant %0d want VID", grants); end
                grants++;
            end
            if (vid_ack) begin
                total++; if (grants % 2 != 1) begin bad++; $display("FAIL cont_order: got VID at grant %0d want CPU", grants); end
                total++; if (vid_dat !== exp_v) begin bad++; $display("FAIL cont_vdat: got %h want %h", vid_dat, exp_v); end
                va = 15'($urandom); vid_adr = va; exp_v = ref_mem[va];
                grants++;
            end
        end
        cpu_stb = 1'b0; vid_cyc = 1'b0;
        total++; if (grants !== 4) begin bad++; $display("FAIL cont_grants: got %0d want 4", grants); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        do_reset();
        wait_n = 0; block_ack = 1'b1; put(15'h0020, 16'h8005); ins_adr = 13'h0020;
        cpu_stb = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (mem_stb !== 1'b0 || cpu_ack !== 1'b0) begin
            bad++; $display("FAIL midrst_abort: got stb %b ack %b want 0 0", mem_stb, cpu_ack); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (mem_stb !== 1'b1 || mem_adr !== 15'h0020 || mem_we !== 1'b0) begin
            bad++; $display("FAIL midrst_restart: got stb %b adr %h we %b want 1 0020 0", mem_stb, mem_adr, mem_we); end
        block_ack = 1'b0;
        watch(0, 50); cpu_stb = 1'b0;
        total++; if (obs_lat !== 2 || obs_idat !== 16'h8005) begin
            bad++; $display("FAIL midrst_finish: got lat %0d word %h want 2 8005", obs_lat, obs_idat); end
        @(negedge clk);
    endtask

    task automatic test_dropped_vid();
        int acks;
        logic [14:0] va;
        logic [15:0] cap;
        wait_n = 3; va = 15'($urandom); vid_adr = va; vid_cyc = 1'b1;
        acks = 0; cap = 16'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_stb && vid_cyc) vid_cyc = 1'b0;
            if (vid_ack) begin acks++; cap = vid_dat; end
        end
        total++; if (acks !== 1) begin bad++; $display("FAIL drop_acks: got %0d want 1", acks); end
        total++; if (cap !== ref_mem[va]) begin bad++; $display("FAIL drop_data: got %h want %h", cap, ref_mem[va]); end
        // stray memory acks outside bus phases must be ignored
        force_ack = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ack || vid_ack || mem_stb) acks++;
        end
        force_ack = 1'b0;
        total++; if (acks !== 0 || vid_dat !== ref_mem[va]) begin
            bad++; $display("FAIL idle_ack_ignored: got %0d events vdat %h want 0 %h", acks, vid_dat, ref_mem[va]); end
    endtask

    task automatic test_random();
        logic [15:0] exp_cdat;
        logic [31:0] r;
        logic [15:0] instr, wd;
        logic [14:0] da, va;
        logic [12:0] ia;
        bit          need, wr;
        int          w;
        do_reset();
        exp_cdat = 16'h0000;
        for (int t = 0; t < 40; t++) begin
            w = int'($urandom_range(0, 3)); wait_n = w;
            if ($urandom_range(0, 2) == 0) begin
                va = 15'($urandom); vid_adr = va; vid_cyc = 1'b1;
                watch(1, 100); vid_cyc = 1'b0;
                total++; if (obs_lat !== 2 + w || obs_n !== 1 || obs_adr[0] !== va || obs_we[0] !== 1'b0 || obs_wrong !== 0) begin
                    bad++; $display("FAIL rnd_vid_bus: got lat %0d n %0d adr %h we %b want %0d 1 %h 0",
                                    obs_lat, obs_n, obs_adr[0], obs_we[0], 2 + w, va); end
                total++; if (obs_vdat !== ref_mem[va]) begin
                    bad++; $display("FAIL rnd_vid_data: got %h want %h", obs_vdat, ref_mem[va]); end
            end else begin
                r = $urandom;
                case ($urandom_range(0, 3))
                    0:       instr = {3'b011, r[12:0]};
                    1:       instr = {3'b011, r[12], 4'hC, r[7:0]};
                    2:       instr = {3'b011, r[12:6], 1'b1, r[4:0]};
                    default: instr = r[15:0];
                endcase
                ia = 13'($urandom); da = 15'($urandom); wd = 16'($urandom);
                put({2'b00, ia}, instr);
                need = (instr[15:13] == 3'b011) && ((instr[11:8] == 4'hC) || instr[5]);
                wr   = (instr[15:13] == 3'b011) && instr[5];
                ins_adr = ia; dat_adr = da; dat_wd = wd; cpu_stb = 1'b1;
                watch(0, 100); cpu_stb = 1'b0;
                if (need && !wr) exp_cdat = ref_mem[da];
                if (need && wr)  ref_mem[da] = wd;
                total++; if (obs_lat !== (need ? 4 + 2 * w : 3 + w) || obs_n !== (need ? 2 : 1) || obs_wrong !== 0) begin
                    bad++; $display("FAIL rnd_cpu_timing: instr %h got lat %0d n %0d want %0d %0d",
                                    instr, obs_lat, obs_n, need ? 4 + 2 * w : 3 + w, need ? 2 : 1); end
                total++; if (obs_adr[0] !== {2'b00, ia} || obs_we[0] !== 1'b0) begin
                    bad++; $display("FAIL rnd_cpu_ins: got adr %h we %b want %h 0", obs_adr[0], obs_we[0], {2'b00, ia}); end
                if (need) begin
                    total++; if (obs_adr[1] !== da || obs_we[1] !== wr || (wr && obs_wd[1] !== wd)) begin
                        bad++; $display("FAIL rnd_cpu_dat: got adr %h we %b wd %h want %h %b %h",
                                        obs_adr[1], obs_we[1], obs_wd[1], da, wr, wd); end
                end
                total++; if (obs_idat !== instr || obs_cdat !== exp_cdat) begin
                    bad++; $display("FAIL rnd_cpu_data: got ins %h dat %h want %h %h", obs_idat, obs_cdat, instr, exp_cdat); end
            end
            total++; if (obs_cycbad !== 0) begin bad++; $display("FAIL rnd_cyc_eq_stb: got %0d diffs want 0", obs_cycbad); end
            @(negedge clk);
            total++; if (cpu_ack !== 1'b0 || vid_ack !== 1'b0) begin
                bad++; $display("FAIL rnd_ack_pulse: got %b%b want 00", cpu_ack, vid_ack); end
        end
    endtask

    initial begin
        rst = 1'b1; cpu_stb = 1'b0; vid_cyc = 1'b0;
        ins_adr = '0; dat_adr = '0; dat_wd = '0; vid_adr = '0;
        wait_n = 0; block_ack = 1'b0; force_ack = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_fetch();
        test_load_store();
        test_contention();
        test_mid_reset();
        test_dropped_vid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
